// File: rtl/seq_pkg.sv
// Shared definitions for the fullchip instruction sequencer: inst field map and phase encoding.
package seq_pkg;

  localparam int unsigned InstW = 27;

  // Field bit positions in the 27-bit inst word. norm_rd (21), norm (20), vmem_wr (4) and
  // nmem_wr (2) are never driven by the sequencer and only reach fullchip through host_inst.
  localparam int unsigned BitNormAddLsb  = 23;
  localparam int unsigned BitNormWr      = 22;
  localparam int unsigned BitDiv         = 19;
  localparam int unsigned BitAcc         = 18;
  localparam int unsigned BitColC        = 17;
  localparam int unsigned BitOfifoRd     = 16;
  localparam int unsigned BitVnmemAddLsb = 12;
  localparam int unsigned BitPmemAddLsb  = 8;
  localparam int unsigned BitExecute     = 7;
  localparam int unsigned BitLoad        = 6;
  localparam int unsigned BitVmemRd      = 5;
  localparam int unsigned BitNmemRd      = 3;
  localparam int unsigned BitPmemRd      = 1;
  localparam int unsigned BitPmemWr      = 0;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StGap1  = 3'd2,
    StExec  = 3'd3,
    StGap2  = 3'd4,
    StDrain = 3'd5,
    StNorm  = 3'd6,
    StDone  = 3'd7
  } phase_e;

  // Counter width large enough for the longest phase (LOAD, GAP or a full NORM pass).
  function automatic int unsigned cnt_width(int unsigned col, int unsigned gap,
                                            int unsigned addr_w, int unsigned norm_lat);
    int unsigned m;
    m = col + 2;
    if (gap > m) m = gap;
    if ((2 ** addr_w) + norm_lat > m) m = (2 ** addr_w) + norm_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_cnt.sv
// Loadable up-counter with enable and terminal-count flag; one instance serves every phase.
module seq_cnt #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/inst_sequencer.sv
// Steps fullchip through N load, V execute, ofifo->pmem drain and optional norm pass,
// emitting one registered inst word per cycle; passes host_inst through while idle.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned COL      = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned INST_W   = InstW,
  parameter int unsigned GAP      = 10,
  parameter int unsigned NORM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              mode_i,
  input  logic              norm_en_i,
  input  logic [ADDR_W:0]   n_vec_i,
  input  logic [INST_W-1:0] host_inst_i,
  input  logic              ofifo_valid_i,
  output logic [INST_W-1:0] inst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        phase_o
);

  localparam int unsigned CntW = cnt_width(COL, GAP, ADDR_W, NORM_LAT);

  phase_e              state_q, state_d;
  logic                mode_q, norm_en_q;
  logic [ADDR_W:0]     n_vec_q;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                latch;
  logic                kill;

  logic                cnt_load;
  logic                cnt_en;
  logic [CntW-1:0]     cnt_last;
  logic [CntW-1:0]     cnt;
  logic                cnt_tc;
  logic [CntW-1:0]     n_ext;

  assign n_ext = CntW'(n_vec_q);
  assign kill  = abort_i && (state_q != StIdle);

  seq_cnt #(
    .Width (CntW)
  ) u_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .last_i     (cnt_last),
    .cnt_o      (cnt),
    .tc_o       (cnt_tc)
  );

  // Next state and counter control; every state entry reloads the counter to 0.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_last = '0;
    latch    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_load = 1'b1;
        if (start_i) begin
          latch   = 1'b1;
          state_d = (n_vec_i != '0) ? StLoad : StDone;
        end
      end
      StLoad: begin
        cnt_en   = 1'b1;
        cnt_last = CntW'(COL + 1);
        if (cnt_tc) begin
          state_d  = StGap1;
          cnt_load = 1'b1;
        end
      end
      StGap1: begin
        cnt_en   = 1'b1;
        cnt_last = CntW'(GAP - 1);
        if (cnt_tc) begin
          state_d  = StExec;
          cnt_load = 1'b1;
        end
      end
      StExec: begin
        cnt_en   = 1'b1;
        cnt_last = n_ext - CntW'(1);
        if (cnt_tc) begin
          state_d  = StGap2;
          cnt_load = 1'b1;
        end
      end
      StGap2: begin
        cnt_en   = 1'b1;
        cnt_last = CntW'(GAP - 1);
        if (cnt_tc) begin
          state_d  = StDrain;
          cnt_load = 1'b1;
        end
      end
      StDrain: begin
        // Only cycles with a row in the ofifo count towards the drain.
        cnt_en   = ofifo_valid_i;
        cnt_last = n_ext - CntW'(1);
        if (ofifo_valid_i && cnt_tc) begin
          state_d  = norm_en_q ? StNorm : StDone;
          cnt_load = 1'b1;
        end
      end
      StNorm: begin
        cnt_en   = 1'b1;
        cnt_last = n_ext + CntW'(NORM_LAT) - CntW'(1);
        if (cnt_tc) begin
          state_d  = StDone;
          cnt_load = 1'b1;
        end
      end
      StDone: begin
        cnt_load = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        cnt_load = 1'b1;
        state_d  = StIdle;
      end
    endcase
    if (kill) begin
      state_d  = StIdle;
      cnt_load = 1'b1;
    end
  end

  // Word builder: the word for the current state/count is registered on the next edge.
  always_comb begin
    inst_d = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_q != StIdle && state_q != StDone) begin
      inst_d[BitColC] = mode_q;
      busy_d          = 1'b1;
    end
    case (state_q)
      StIdle: inst_d = host_inst_i;
      StLoad: begin
        inst_d[BitLoad] = 1'b1;
        if (cnt >= CntW'(1) && cnt <= CntW'(COL)) begin
          inst_d[BitNmemRd] = 1'b1;
        end
        if (cnt >= CntW'(2) && cnt <= CntW'(COL)) begin
          inst_d[BitVnmemAddLsb +: ADDR_W] = ADDR_W'(cnt - CntW'(1));
        end
      end
      StExec: begin
        inst_d[BitExecute]               = 1'b1;
        inst_d[BitVmemRd]                = 1'b1;
        inst_d[BitVnmemAddLsb +: ADDR_W] = ADDR_W'(cnt);
      end
      StDrain: begin
        if (ofifo_valid_i) begin
          inst_d[BitOfifoRd]              = 1'b1;
          inst_d[BitPmemWr]               = 1'b1;
          inst_d[BitPmemAddLsb +: ADDR_W] = ADDR_W'(cnt);
        end
      end
      StNorm: begin
        if (cnt < n_ext) begin
          inst_d[BitPmemRd]               = 1'b1;
          inst_d[BitPmemAddLsb +: ADDR_W] = ADDR_W'(cnt);
        end
        // Norm writes trail pmem reads by the pmem_rd-to-norm_wr latency.
        if (cnt >= CntW'(NORM_LAT)) begin
          inst_d[BitAcc]                  = 1'b1;
          inst_d[BitDiv]                  = 1'b1;
          inst_d[BitNormWr]               = 1'b1;
          inst_d[BitNormAddLsb +: ADDR_W] = ADDR_W'(cnt - CntW'(NORM_LAT));
        end
      end
      StDone:  done_d = 1'b1;
      default: inst_d = inst_d;
    endcase
    if (kill) begin
      inst_d = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      norm_en_q <= 1'b0;
      n_vec_q   <= '0;
      inst_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (latch) begin
        mode_q    <= mode_i;
        norm_en_q <= norm_en_i;
        n_vec_q   <= n_vec_i;
      end
    end
  end

  assign inst_o  = inst_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign phase_o = state_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Randomized self-checking bench for inst_sequencer against a phase-list reference model.
module tb_inst_sequencer;

  localparam int COL  = 8;
  localparam int GAP  = 10;
  localparam int NLAT = 2;

  localparam int B_NORM_WR = 22;
  localparam int B_DIV     = 19;
  localparam int B_ACC     = 18;
  localparam int B_COLC    = 17;
  localparam int B_OFIFO   = 16;
  localparam int B_EXEC    = 7;
  localparam int B_LOAD    = 6;
  localparam int B_VMEM_RD = 5;
  localparam int B_NMEM_RD = 3;
  localparam int B_PMEM_RD = 1;
  localparam int B_PMEM_WR = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        mode;
  logic        norm_en;
  logic [4:0]  n_vec;
  logic [26:0] host_inst;
  logic        ofifo_valid;
  logic [26:0] inst;
  logic        busy;
  logic        done;
  logic [2:0]  phase;

  int errors = 0;
  int checks = 0;

  logic [26:0] exp_q[$];
  bit          vv[600];

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .abort_i       (abort),
    .mode_i        (mode),
    .norm_en_i     (norm_en),
    .n_vec_i       (n_vec),
    .host_inst_i   (host_inst),
    .ofifo_valid_i (ofifo_valid),
    .inst_o        (inst),
    .busy_o        (busy),
    .done_o        (done),
    .phase_o       (phase)
  );

  // Reference: the ordered list of job words, phase by phase. vv[i] is the ofifo_valid seen
  // while word i is being formed. vpat 0: always valid, 1: alternating in DRAIN, 2: random.
  task automatic build_model(input int n, input bit md, input bit ne, input int vpat);
    int          d0;
    int          acc;
    logic [26:0] w;
    logic [3:0]  a;
    d0 = COL + 2 + GAP + n + GAP;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      case (vpat)
        0:       vv[i] = 1'b1;
        1:       vv[i] = (i < d0) ? 1'($urandom) : (((i - d0) % 2) == 1);
        default: vv[i] = (i >= 400) || ($urandom_range(0, 2) != 0);
      endcase
    end
    if (n == 0) return;
    for (int k = 0; k < COL + 2; k++) begin
      w = '0; w[B_COLC] = md; w[B_LOAD] = 1'b1;
      if (k >= 1 && k <= COL) w[B_NMEM_RD] = 1'b1;
      if (k >= 2 && k <= COL) begin a = 4'(k - 1); w[15:12] = a; end
      exp_q.push_back(w);
    end
    for (int k = 0; k < GAP; k++) begin w = '0; w[B_COLC] = md; exp_q.push_back(w); end
    for (int k = 0; k < n; k++) begin
      w = '0; w[B_COLC] = md; w[B_EXEC] = 1'b1; w[B_VMEM_RD] = 1'b1;
      a = 4'(k); w[15:12] = a;
      exp_q.push_back(w);
    end
    for (int k = 0; k < GAP; k++) begin w = '0; w[B_COLC] = md; exp_q.push_back(w); end
    acc = 0;
    while (acc < n) begin
      w = '0; w[B_COLC] = md;
      if (vv[exp_q.size()]) begin
        w[B_OFIFO] = 1'b1; w[B_PMEM_WR] = 1'b1; a = 4'(acc); w[11:8] = a;
        acc++;
      end
      exp_q.push_back(w);
    end
    if (ne) begin
      for (int k = 0; k < n + NLAT; k++) begin
        w = '0; w[B_COLC] = md;
        if (k < n) begin w[B_PMEM_RD] = 1'b1; a = 4'(k); w[11:8] = a; end
        if (k >= NLAT) begin
          w[B_ACC] = 1'b1; w[B_DIV] = 1'b1; w[B_NORM_WR] = 1'b1;
          a = 4'(k - NLAT); w[26:23] = a;
        end
        exp_q.push_back(w);
      end
    end
  endtask

  // One job: start in IDLE, then every later input except ofifo_valid is scrambled.
  task automatic run_job(input int n, input bit md, input bit ne, input int vpat,
                         input int abort_step, input bit abort_with_start, input string name);
    int          m;
    logic [26:0] h;
    logic [2:0]  exp_ph;
    build_model(n, md, ne, vpat);
    m = exp_q.size();
    h = 27'($urandom);
    host_inst = h; start = 1'b1; abort = abort_with_start; n_vec = 5'(n);
    mode = md; norm_en = ne; ofifo_valid = 1'($urandom);
    @(posedge clk); #1;
    exp_ph = (n != 0) ? 3'd1 : 3'd7;
    checks++;
    if (inst !== h) begin
      errors++; $display("FAIL %s start_word: inst=%h expected %h", name, inst, h);
    end
    checks++;
    if (phase !== exp_ph) begin
      errors++; $display("FAIL %s start_phase: phase=%0d expected %0d", name, phase, exp_ph);
    end
    for (int t = 1; t <= m + 1; t++) begin
      start = 1'($urandom); abort = (t == abort_step); host_inst = 27'($urandom);
      mode = 1'($urandom); norm_en = 1'($urandom); n_vec = 5'($urandom);
      ofifo_valid = (t - 1 < m) ? vv[t - 1] : 1'($urandom);
      @(posedge clk); #1;
      if (t == abort_step) begin
        checks++;
        if (inst !== '0 || busy !== 1'b0 || done !== 1'b0 || phase !== 3'd0) begin
          errors++;
          $display("FAIL %s abort@%0d: inst=%h busy=%b done=%b phase=%0d expected 0/0/0/0",
                   name, t, inst, busy, done, phase);
        end
        break;
      end
      checks++;
      if (t <= m) begin
        if (inst !== exp_q[t - 1] || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s word%0d: inst=%h busy=%b done=%b expected inst=%h busy=1 done=0",
                   name, t - 1, inst, busy, done, exp_q[t - 1]);
        end
      end else begin
        if (inst !== '0 || busy !== 1'b0 || done !== 1'b1 || phase !== 3'd0) begin
          errors++;
          $display("FAIL %s done@%0d: inst=%h busy=%b done=%b phase=%0d expected 0/0/1/0",
                   name, t, inst, busy, done, phase);
        end
      end
    end
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done: done=%b busy=%b expected 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; norm_en = 1'b0; n_vec = '0;
    host_inst = 27'h5a5a5a5; ofifo_valid = 1'b0;
    #12;
    checks++;
    if (inst !== '0 || busy !== 1'b0 || done !== 1'b0 || phase !== 3'd0) begin
      errors++;
      $display("FAIL reset: inst=%h busy=%b done=%b phase=%0d expected all 0",
               inst, busy, done, phase);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [26:0] h;
    for (int i = 0; i < 8; i++) begin
      h = 27'($urandom); host_inst = h; abort = 1'($urandom); start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (inst !== h || phase !== 3'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL passthrough%0d: inst=%h phase=%0d busy=%b expected %h/0/0",
                 i, inst, phase, busy, h);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_basic();
    run_job(8, 1'b0, 1'b0, 0, -1, 1'b0, "basic");
  endtask

  task automatic test_norm();
    run_job(8, 1'b1, 1'b1, 0, -1, 1'b0, "norm");
  endtask

  task automatic test_drain_toggle();
    run_job(8, 1'b0, 1'b0, 1, -1, 1'b0, "drain_toggle");
  endtask

  task automatic test_boundaries();
    run_job(0, 1'b1, 1'b1, 0, -1, 1'b0, "nvec0");
    run_job(16, 1'b1, 1'b1, 2, -1, 1'b0, "nvec16");
  endtask

  task automatic test_abort();
    // EXEC k=3 is job word 10+10+3, formed in the cycle before step 24.
    run_job(8, 1'b0, 1'b1, 0, 24, 1'b0, "abort_exec");
    host_inst = 27'h10; abort = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (inst !== 27'h10 || busy !== 1'b0 || phase !== 3'd0) begin
      errors++;
      $display("FAIL abort_host: inst=%h busy=%b phase=%0d expected 0000010/0/0",
               inst, busy, phase);
    end
    abort = 1'b0;
  endtask

  task automatic test_start_with_abort();
    run_job(4, 1'b1, 1'b0, 2, -1, 1'b1, "start_abort");
  endtask

  task automatic test_random_jobs();
    for (int i = 0; i < 6; i++) begin
      run_job($urandom_range(0, 16), 1'($urandom), 1'($urandom), 2, -1, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_drain();
    bit saw_done;
    start = 1'b1; n_vec = 5'd8; mode = 1'b1; norm_en = 1'b1; ofifo_valid = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 42; t++) begin @(posedge clk); #1; end
    checks++;
    if (phase !== 3'd5) begin
      errors++; $display("FAIL mid_drain_phase: phase=%0d expected 5", phase);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (inst !== '0 || busy !== 1'b0 || phase !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drain: inst=%h busy=%b phase=%0d done=%b expected all 0",
               inst, busy, phase, done);
    end
    @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || phase !== 3'd0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL reset_no_done: done or phase moved after reset, expected idle");
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_basic();
    test_norm();
    test_drain_toggle();
    test_boundaries();
    test_abort();
    test_start_with_abort();
    test_random_jobs();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
